// File: rtl/fft_sched_pkg.sv
// Shared definitions for the in-place radix-2 FFT butterfly scheduler:
// state encoding plus size helpers derived from the stage count.
package fft_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_STAGES   = 4;
    localparam int DEF_PIPE_LAT = 3;

    // NPTS = 1 << STAGES
    function automatic int npts_of(input int stages);
        return 1 << stages;
    endfunction

    // Butterflies per stage, NPTS/2
    function automatic int nbfly_of(input int stages);
        return npts_of(stages) / 2;
    endfunction

    function automatic int addr_w(input int stages);
        return stages;
    endfunction

    function automatic int tw_w(input int stages);
        return stages - 1;
    endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational butterfly address generator: (stage, k) -> top/bottom
// sample addresses and twiddle index for an in-place DIT FFT.
module fft_bfly_addr_gen
    import fft_sched_pkg::*;
#(
    parameter int STAGES = DEF_STAGES
) (
    input  logic [STAGES-1:0] i_stage,
    input  logic [STAGES-2:0] i_k,
    output logic [STAGES-1:0] o_addr_a,
    output logic [STAGES-1:0] o_addr_b,
    output logic [STAGES-2:0] o_tw_idx
);

    logic [STAGES-1:0] k_ext;
    logic [STAGES-1:0] half;
    logic [STAGES-1:0] pos;
    logic [STAGES-1:0] hi;
    logic [STAGES-2:0] pos_lo;

    always_comb begin
        k_ext    = {1'b0, i_k};
        half     = STAGES'(1) << i_stage;
        pos      = k_ext & (half - STAGES'(1));
        // Insert a zero bit at position 'stage' to split k into group/offset
        hi       = (k_ext >> i_stage) << (i_stage + STAGES'(1));
        o_addr_a = hi | pos;
        o_addr_b = o_addr_a | half;
        // pos < 2^stage <= 2^(STAGES-1), so the top bit is always zero here
        pos_lo   = pos[STAGES-2:0];
        o_tw_idx = pos_lo << (STAGES'(STAGES - 1) - i_stage);
    end

endmodule

// File: rtl/fft_bfly_scheduler.sv
// Sequencer sharing one butterfly across all FFT stages: issues dual reads,
// twiddle indices and PIPE_LAT-delayed write-backs, then pulses o_done.
module fft_bfly_scheduler
    import fft_sched_pkg::*;
#(
    parameter int STAGES   = DEF_STAGES,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [STAGES-1:0] o_stage,
    output logic              o_rd_en,
    output logic [STAGES-1:0] o_rd_addr_a,
    output logic [STAGES-1:0] o_rd_addr_b,
    output logic [STAGES-2:0] o_tw_idx,
    output logic              o_wr_en,
    output logic [STAGES-1:0] o_wr_addr_a,
    output logic [STAGES-1:0] o_wr_addr_b
);

    localparam int AW = addr_w(STAGES);
    localparam int TW = tw_w(STAGES);
    localparam int NB = nbfly_of(STAGES);
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [TW-1:0] K_LAST     = TW'(NB - 1);
    localparam logic [AW-1:0] STAGE_LAST = AW'(STAGES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] stage_q, stage_d;
    logic [TW-1:0] k_q, k_d;
    logic [DW-1:0] drain_q, drain_d;

    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_a_q, rd_a_d;
    logic [AW-1:0] rd_b_q, rd_b_d;
    logic [TW-1:0] tw_q, tw_d;

    logic [AW-1:0] gen_a, gen_b;
    logic [TW-1:0] gen_tw;

    logic          pipe_en_q [PIPE_LAT];
    logic [AW-1:0] pipe_a_q  [PIPE_LAT];
    logic [AW-1:0] pipe_b_q  [PIPE_LAT];

    // Addresses are generated for the upcoming cycle so the read port is registered
    fft_bfly_addr_gen #(
        .STAGES(STAGES)
    ) u_addr_gen (
        .i_stage (stage_d),
        .i_k     (k_d),
        .o_addr_a(gen_a),
        .o_addr_b(gen_b),
        .o_tw_idx(gen_tw)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RUN;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            RUN: begin
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + TW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + AW'(1);
                        k_d     = '0;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rd_en_d = (state_d == RUN);
        rd_a_d  = rd_en_d ? gen_a  : '0;
        rd_b_d  = rd_en_d ? gen_b  : '0;
        tw_d    = rd_en_d ? gen_tw : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            k_q     <= '0;
            drain_q <= '0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            rd_en_q <= rd_en_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            tw_q    <= tw_d;
        end
    end

    // Write-back is the read strobe/addresses delayed by the read+butterfly latency
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_en_q[i] <= 1'b0;
                pipe_a_q[i]  <= '0;
                pipe_b_q[i]  <= '0;
            end
        end else begin
            pipe_en_q[0] <= rd_en_q;
            pipe_a_q[0]  <= rd_a_q;
            pipe_b_q[0]  <= rd_b_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe_en_q[i] <= pipe_en_q[i-1];
                pipe_a_q[i]  <= pipe_a_q[i-1];
                pipe_b_q[i]  <= pipe_b_q[i-1];
            end
        end
    end

    assign o_busy      = (state_q == RUN) || (state_q == DRAIN);
    assign o_done      = (state_q == DONE);
    assign o_stage     = stage_q;
    assign o_rd_en     = rd_en_q;
    assign o_rd_addr_a = rd_a_q;
    assign o_rd_addr_b = rd_b_q;
    assign o_tw_idx    = tw_q;
    assign o_wr_en     = pipe_en_q[PIPE_LAT-1];
    assign o_wr_addr_a = pipe_a_q[PIPE_LAT-1];
    assign o_wr_addr_b = pipe_b_q[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Self-checking bench: two scheduler configurations driven by directed and
// random start/reset stimulus, compared every cycle to a timeline model.
module tb_fft_bfly_scheduler;

    localparam int S_A = 4, PL_A = 3;
    localparam int S_B = 3, PL_B = 1;
    localparam int LOGN = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;

    logic           busy_a, done_a, rd_en_a, wr_en_a;
    logic [S_A-1:0] stage_a, ra_a, rb_a, wa_a, wb_a;
    logic [S_A-2:0] tw_a;
    logic           busy_b, done_b, rd_en_b, wr_en_b;
    logic [S_B-1:0] stage_b, ra_b, rb_b, wa_b, wb_b;
    logic [S_B-2:0] tw_b;

    fft_bfly_scheduler #(.STAGES(S_A), .PIPE_LAT(PL_A)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_busy(busy_a), .o_done(done_a), .o_stage(stage_a),
        .o_rd_en(rd_en_a), .o_rd_addr_a(ra_a), .o_rd_addr_b(rb_a), .o_tw_idx(tw_a),
        .o_wr_en(wr_en_a), .o_wr_addr_a(wa_a), .o_wr_addr_b(wb_a)
    );

    fft_bfly_scheduler #(.STAGES(S_B), .PIPE_LAT(PL_B)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_busy(busy_b), .o_done(done_b), .o_stage(stage_b),
        .o_rd_en(rd_en_b), .o_rd_addr_a(ra_b), .o_rd_addr_b(rb_b), .o_tw_idx(tw_b),
        .o_wr_en(wr_en_b), .o_wr_addr_a(wa_b), .o_wr_addr_b(wb_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit busy; bit done; bit rd_en; bit wr_en;
        int stage; int ra; int rb; int tw; int wa; int wb;
    } exp_t;

    // Butterfly k of stage s: groups of 2*half points, offset k%half inside a group
    task automatic bfly(input int S, input int s, input int k,
                        output int a, output int b, output int tw);
        int half, nb;
        half = 1 << s;
        nb   = 1 << (S - 1);
        a    = (k / half) * 2 * half + (k % half);
        b    = a + half;
        tw   = (k % half) * (nb / half);
    endtask

    // Expected outputs in cycle c for a transform whose start was taken in cycle t0
    task automatic model(input int c, input int t0, input bit valid,
                         input int S, input int PL, output exp_t e);
        int nb, per, rel, rw, a, b, tw;
        e = '{default: 0};
        if (valid) begin
            nb  = 1 << (S - 1);
            per = nb + PL;
            rel = c - t0 - 1;
            if (rel >= S * per) e.stage = S - 1;
            if (rel == S * per) e.done = 1'b1;
            if (rel >= 0 && rel < S * per) begin
                e.busy  = 1'b1;
                e.stage = rel / per;
                if (rel % per < nb) begin
                    bfly(S, rel / per, rel % per, a, b, tw);
                    e.rd_en = 1'b1; e.ra = a; e.rb = b; e.tw = tw;
                end
                rw = rel - PL;
                if (rw >= 0 && rw % per < nb) begin
                    bfly(S, rw / per, rw % per, a, b, tw);
                    e.wr_en = 1'b1; e.wa = a; e.wb = b;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, c, act, exp);
        end
    endtask

    bit lg_busy_a [LOGN];
    bit lg_done_a [LOGN];
    bit lg_rd_a   [LOGN];
    bit lg_wr_a   [LOGN];
    int lg_stage_a[LOGN];
    int lg_ra_a   [LOGN];
    int lg_rb_a   [LOGN];
    int lg_tw_a   [LOGN];
    int lg_wa_a   [LOGN];
    int lg_wb_a   [LOGN];
    bit lg_done_b [LOGN];
    bit lg_rd_b   [LOGN];
    int lg_tw_b   [LOGN];

    int  t0_a = 0, t0_b = 0;
    bit  v_a = 1'b0, v_b = 1'b0;
    bit  armed = 1'b0;

    always @(negedge clk) begin
        exp_t ea, eb;
        if (armed) begin
            model(cyc, t0_a, v_a, S_A, PL_A, ea);
            chk("A_busy",  cyc, 32'(busy_a),  int'(ea.busy));
            chk("A_done",  cyc, 32'(done_a),  int'(ea.done));
            chk("A_stage", cyc, 32'(stage_a), ea.stage);
            chk("A_rd_en", cyc, 32'(rd_en_a), int'(ea.rd_en));
            chk("A_rd_a",  cyc, 32'(ra_a),    ea.ra);
            chk("A_rd_b",  cyc, 32'(rb_a),    ea.rb);
            chk("A_tw",    cyc, 32'(tw_a),    ea.tw);
            chk("A_wr_en", cyc, 32'(wr_en_a), int'(ea.wr_en));
            chk("A_wr_a",  cyc, 32'(wa_a),    ea.wa);
            chk("A_wr_b",  cyc, 32'(wb_a),    ea.wb);
            model(cyc, t0_b, v_b, S_B, PL_B, eb);
            chk("B_busy",  cyc, 32'(busy_b),  int'(eb.busy));
            chk("B_done",  cyc, 32'(done_b),  int'(eb.done));
            chk("B_stage", cyc, 32'(stage_b), eb.stage);
            chk("B_rd_en", cyc, 32'(rd_en_b), int'(eb.rd_en));
            chk("B_rd_a",  cyc, 32'(ra_b),    eb.ra);
            chk("B_rd_b",  cyc, 32'(rb_b),    eb.rb);
            chk("B_tw",    cyc, 32'(tw_b),    eb.tw);
            chk("B_wr_en", cyc, 32'(wr_en_b), int'(eb.wr_en));
            chk("B_wr_a",  cyc, 32'(wa_b),    eb.wa);
            chk("B_wr_b",  cyc, 32'(wb_b),    eb.wb);
        end
        if (cyc < LOGN) begin
            lg_busy_a[cyc] = busy_a;  lg_done_a[cyc] = done_a;
            lg_rd_a[cyc]   = rd_en_a; lg_wr_a[cyc]   = wr_en_a;
            lg_stage_a[cyc] = int'(stage_a);
            lg_ra_a[cyc] = int'(ra_a); lg_rb_a[cyc] = int'(rb_a); lg_tw_a[cyc] = int'(tw_a);
            lg_wa_a[cyc] = int'(wa_a); lg_wb_a[cyc] = int'(wb_a);
            lg_done_b[cyc] = done_b; lg_rd_b[cyc] = rd_en_b; lg_tw_b[cyc] = int'(tw_b);
        end
        // Start is honoured only when the previous transform has fully returned to idle
        if (rst) begin
            armed = 1'b1;
            v_a = 1'b0;
            v_b = 1'b0;
        end else if (start) begin
            if (!v_a || cyc >= t0_a + 2 + S_A * ((1 << (S_A - 1)) + PL_A)) begin
                t0_a = cyc; v_a = 1'b1;
            end
            if (!v_b || cyc >= t0_b + 2 + S_B * ((1 << (S_B - 1)) + PL_B)) begin
                t0_b = cyc; v_b = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic count_in(input int lo, input int hi, input int which, output int n);
        n = 0;
        for (int i = lo; i <= hi; i++) begin
            case (which)
                0: n += int'(lg_rd_a[i]);
                1: n += int'(lg_wr_a[i]);
                2: n += int'(lg_done_a[i]);
                default: n += int'(lg_busy_a[i]);
            endcase
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        goto(3);
        rst = 1'b0;

        // Single transform, start in cycle 5
        goto(5);  start = 1'b1;
        goto(6);  start = 1'b0;

        // Start held high across a whole transform and beyond
        goto(60);  start = 1'b1;
        goto(121); start = 1'b0;

        // Abort by reset mid-run, then restart
        goto(160); start = 1'b1;
        goto(161); start = 1'b0;
        goto(180); rst = 1'b1;
        goto(181); rst = 1'b0;
        goto(190); start = 1'b1;
        goto(191); start = 1'b0;

        goto(250);
        while (cyc < 3250) begin
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        start = 1'b0;
        rst = 1'b0;
        goto(3300);

        // Literal pins for the first transform (start in cycle 5)
        chk("L_rd0_a",  6, 32'(lg_ra_a[6]), 0);
        chk("L_rd0_b",  6, 32'(lg_rb_a[6]), 1);
        chk("L_stage0", 6, 32'(lg_stage_a[6]), 0);
        chk("L_rd7_a", 13, 32'(lg_ra_a[13]), 14);
        chk("L_rd7_b", 13, 32'(lg_rb_a[13]), 15);
        chk("L_rd7_tw", 13, 32'(lg_tw_a[13]), 0);
        chk("L_wr0_en", 9, 32'(lg_wr_a[9]), 1);
        chk("L_wr0_a",  9, 32'(lg_wa_a[9]), 0);
        chk("L_wr0_b",  9, 32'(lg_wb_a[9]), 1);
        chk("L_wr_pre", 8, 32'(lg_wr_a[8]), 0);
        for (int c = 14; c <= 16; c++) chk("L_drain_rd", c, 32'(lg_rd_a[c]), 0);
        chk("L_wr7_en", 16, 32'(lg_wr_a[16]), 1);
        chk("L_wr7_a",  16, 32'(lg_wa_a[16]), 14);
        chk("L_wr_gap", 17, 32'(lg_wr_a[17]), 0);
        chk("L_s1_first_rd", 17, 32'(lg_rd_a[17]), 1);
        chk("L_s1_first_b",  17, 32'(lg_rb_a[17]), 2);
        chk("L_s1k1_a", 18, 32'(lg_ra_a[18]), 1);
        chk("L_s1k1_b", 18, 32'(lg_rb_a[18]), 3);
        chk("L_s1k1_tw", 18, 32'(lg_tw_a[18]), 4);
        chk("L_s2k5_a", 33, 32'(lg_ra_a[33]), 9);
        chk("L_s2k5_b", 33, 32'(lg_rb_a[33]), 13);
        chk("L_s2k5_tw", 33, 32'(lg_tw_a[33]), 2);
        chk("L_s3k7_a", 46, 32'(lg_ra_a[46]), 7);
        chk("L_s3k7_b", 46, 32'(lg_rb_a[46]), 15);
        chk("L_s3k7_tw", 46, 32'(lg_tw_a[46]), 7);
        chk("L_done", 50, 32'(lg_done_a[50]), 1);
        count_in(6, 59, 2, n); chk("L_done_count", 59, 32'(n), 1);
        count_in(6, 59, 0, n); chk("L_read_count", 59, 32'(n), 32);
        count_in(6, 59, 1, n); chk("L_write_count", 59, 32'(n), 32);
        count_in(6, 59, 3, n); chk("L_busy_count", 59, 32'(n), 44);
        chk("L_busy_first", 6, 32'(lg_busy_a[6]), 1);
        chk("L_busy_last", 49, 32'(lg_busy_a[49]), 1);

        // Continuous start from cycle 60
        count_in(61, 104, 2, n); chk("L_cont_nodone", 104, 32'(n), 0);
        chk("L_cont_done", 105, 32'(lg_done_a[105]), 1);
        chk("L_cont_idle", 106, 32'(lg_rd_a[106]), 0);
        chk("L_cont_rerun", 107, 32'(lg_rd_a[107]), 1);

        // Reset in cycle 180, restart in cycle 190
        chk("L_rst_busy", 181, 32'(lg_busy_a[181]), 0);
        chk("L_rst_rd",   181, 32'(lg_rd_a[181]), 0);
        chk("L_rst_wr",   181, 32'(lg_wr_a[181]), 0);
        chk("L_rst_stage", 181, 32'(lg_stage_a[181]), 0);
        count_in(181, 234, 2, n); chk("L_rst_nodone", 234, 32'(n), 0);
        chk("L_rst_redone", 235, 32'(lg_done_a[235]), 1);

        // Small configuration: STAGES=3, PIPE_LAT=1
        chk("L_B_done", 21, 32'(lg_done_b[21]), 1);
        chk("L_B_nodone", 20, 32'(lg_done_b[20]), 0);
        for (int k = 0; k < 4; k++) begin
            chk("L_B_s2_rd", 16 + k, 32'(lg_rd_b[16 + k]), 1);
            chk("L_B_s2_tw", 16 + k, 32'(lg_tw_b[16 + k]), k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_bfly_scheduler.md
Name: fft_bfly_scheduler

Overview:
Sequencer for an in-place radix-2 DIT FFT that shares one butterfly unit across all stages and time-multiplexes it. On a start pulse it walks STAGES stages of 2^(STAGES-1) butterflies each. For every butterfly it issues:
- a dual read of the sample RAM,
- the twiddle ROM index,
- the delayed write-back of the butterfly results.

It sits between the sample loader (which fills the RAM in bit-reversed order) and the output unloader, and raises o_done when the transform is complete.

Parameters:
STAGES, 4, log2 of FFT points; the FFT has NPTS = 2^STAGES points.
PIPE_LAT, 3, cycles from o_rd_en to the matching o_wr_en (RAM read latency plus butterfly latency); must be >= 1.

Ports:
i_clk  in  1  clock; all logic is on the rising edge.
i_rst  in  1  synchronous reset, active-high.
i_start  in  1  start request; sampled only in IDLE.
o_busy  out  1  high in RUN and DRAIN.
o_done  out  1  one-cycle pulse when the transform is complete.
o_stage  out  STAGES bits (log2 sized)  current stage number, 0..STAGES-1.
o_rd_en  out  1  read strobe for both RAM ports.
o_rd_addr_a  out  STAGES  butterfly top address.
o_rd_addr_b  out  STAGES  butterfly bottom address.
o_tw_idx  out  STAGES-1  twiddle ROM index, W_NPTS^idx.
o_wr_en  out  1  write-back strobe for both ports.
o_wr_addr_a  out  STAGES  write address, top result.
o_wr_addr_b  out  STAGES  write address, bottom result.

Behaviour:
- Reset (synchronous, active-high) forces state IDLE and zeroes every output, the stage counter, the butterfly counter k and all delay-line valid bits. Reset mid-operation aborts immediately: no further writes and no o_done.
- State machine:
  - IDLE -> RUN when i_start = 1. Stage = 0, k = 0.
  - RUN: one butterfly per cycle. o_rd_en = 1. k increments. When k = NPTS/2-1, the next state is DRAIN.
  - DRAIN: lasts exactly PIPE_LAT cycles, o_rd_en = 0. This guarantees the last write of a stage lands before the first read of the next stage; RAM read-during-write behaviour is irrelevant. At the end of DRAIN: if stage < STAGES-1, stage increments, k = 0, and the next state is RUN; otherwise the next state is DONE.
  - DONE: o_done = 1 for one cycle, o_busy = 0, then IDLE.
- Address generation for stage s and butterfly k:
  - half = 2^s
  - pos = k & (half-1)
  - a = ((k >> s) << (s+1)) | pos
  - b = a + half
  - tw = pos << (STAGES-1-s)
  - All values are unsigned and never overflow their port widths.
- Write-back path:
  - o_wr_en, o_wr_addr_a and o_wr_addr_b are exact copies of o_rd_en, o_rd_addr_a and o_rd_addr_b delayed by PIPE_LAT cycles through a shift register.
  - When wr_en is 0, the write addresses are held at 0.
- Timing with start sampled in cycle 0:
  - first read in cycle 1;
  - each stage occupies NPTS/2 + PIPE_LAT cycles;
  - o_done in cycle 1 + STAGES*(NPTS/2 + PIPE_LAT). With the defaults this is cycle 45.
- i_start is ignored in RUN, DRAIN and DONE; there is no queuing. A start arriving in the cycle after DONE (i.e. in IDLE) is accepted normally.
- o_stage and the read outputs are registered. o_rd_addr_* and o_tw_idx hold 0 when o_rd_en = 0.

Decomposition:
- Package fft_sched_pkg holds:
  - the state encoding: IDLE, RUN, DRAIN, DONE;
  - the constant NPTS = 1 << STAGES;
  - the NPTS/2 butterfly count;
  - the width helpers for address and twiddle fields.
- Sub-module fft_bfly_addr_gen is purely combinational: (stage, k) -> (a, b, tw). It is unit-testable on its own.
- The PIPE_LAT delay line stays inline in the scheduler.

Test Plan:
1. Reset, then pulse start in cycle 0. Required: reads in cycles 1..8 give (a,b,tw) = (0,1,0), (2,3,0) … (14,15,0). o_stage = 0. Writes with the same addresses appear in cycles 4..11.
2. Full run with the defaults. Required: stage 1, k = 1 -> (1,3,4); stage 2, k = 5 -> (9,13,2); stage 3, k = 7 -> (7,15,7). o_done is high only in cycle 45. Exactly 32 reads and 32 writes occur. o_busy is high in cycles 1..44.
3. Stage boundary. Required: the last read of stage 0 is in cycle 8, no reads in cycles 9..11, its last write is in cycle 11, and the first read of stage 1 is in cycle 12.
4. Start asserted continuously from cycle 0 through cycle 60. Required: o_done in cycle 45 only. A second transform starts its reads in cycle 47 (IDLE in cycle 46 samples start).
5. Assert i_rst in cycle 20, then release. Required: from cycle 21 all outputs are 0 and no o_done ever fires. A new start in cycle 30 gives o_done in cycle 75.
6. STAGES = 3, PIPE_LAT = 1. Required: o_done in cycle 1 + 3*(4+1) = 16. The stage 2 twiddles are 0, 1, 2, 3.
